// File: rtl/led_scan_pkg.sv
// Shared constants, FSM state codes and digit helpers for the LED scan driver.
// Latency: n/a (combinational helpers only).
// Backpressure: n/a.
package led_scan_pkg;

  localparam int          DIGITS    = 4;
  localparam int          IDX_W     = 2;
  localparam logic [3:0]  BCD_MAX   = 4'd9;
  localparam logic [3:0]  NUM_BLANK = 4'hF;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } scan_state_t;

  // Raw nibble of digit idx from a packed {d3,d2,d1,d0} word.
  function automatic logic [3:0] digit_nib(input logic [DIGITS*4-1:0] bcd,
                                           input logic [IDX_W-1:0]    idx);
    return bcd[{idx, 2'b00} +: 4];
  endfunction

  // Value to present on the decoder input: invalid BCD is replaced by NUM_BLANK.
  function automatic logic [3:0] digit_num(input logic [DIGITS*4-1:0] bcd,
                                           input logic [IDX_W-1:0]    idx);
    logic [3:0] nib;
    nib = digit_nib(bcd, idx);
    return (nib > BCD_MAX) ? NUM_BLANK : nib;
  endfunction

  // A digit is dark if it is invalid BCD, or (with leading-zero blanking)
  // if it and every more significant digit are zero. d0 always shows.
  // An invalid nibble is nonzero, so it keeps lower zeros visible.
  function automatic logic digit_hidden(input logic [DIGITS*4-1:0] bcd,
                                        input logic [IDX_W-1:0]    idx,
                                        input logic                lzb);
    logic [3:0] nib;
    logic       higher_zero;
    nib         = digit_nib(bcd, idx);
    higher_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i > int'(idx) && bcd[i*4 +: 4] != 4'd0) higher_zero = 1'b0;
    end
    return (nib > BCD_MAX) ||
           (lzb && (idx != '0) && (nib == 4'd0) && higher_zero);
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Slot prescaler: counts sys_clk cycles within a digit slot and tracks the BLANK/SHOW phase.
// Latency: slot_start/slot_end/in_blank describe the current count (no extra delay).
// Backpressure: en=0 freezes the count and the phase; no restart of the blank window.
// Ports: sys_clk, sys_rst (sync, active-high), en in; slot_start, slot_end, in_blank out.
module led_scan_timer
  import led_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  output logic slot_start,
  output logic slot_end,
  output logic in_blank
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
  // With no blank window the phase machine never leaves SHOW.
  localparam scan_state_t RST_STATE = (BLANK_CYC > 0) ? S_BLANK : S_SHOW;

  logic [CNT_W-1:0] slot_cnt;
  logic [CNT_W-1:0] cnt_next;
  scan_state_t      state;
  scan_state_t      state_next;

  assign slot_start = (slot_cnt == '0);
  assign slot_end   = (slot_cnt == CNT_LAST);
  assign in_blank   = (state == S_BLANK);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      slot_cnt <= '0;
      state    <= RST_STATE;
    end else begin
      slot_cnt <= cnt_next;
      state    <= state_next;
    end
  end

  // Phase is derived from the count the register is about to hold, so
  // state always agrees with slot_cnt, including across en=0 holds.
  always_comb begin
    cnt_next   = slot_cnt;
    state_next = state;
    if (en) begin
      cnt_next   = slot_end ? '0 : slot_cnt + CNT_W'(1);
      state_next = ((BLANK_CYC != 0) && (cnt_next < BLANK_LIM)) ? S_BLANK : S_SHOW;
    end
  end

endmodule

// File: rtl/led_scan_driver.sv
// 4-digit time-multiplexed scan source: frame snapshot, dead-time blank, LZB and invalid-BCD masking.
// Latency: all outputs registered, one cycle behind the slot counter state.
// Backpressure: en=0 holds counters/snapshot and forces blank; no handshake downstream.
// Ports: sys_clk, sys_rst, en, bcd_in[15:0] in; num_out[3:0], ctrl_led[1:0], blank, frame_done out.
module led_scan_driver
  import led_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter bit LZB_EN    = 1'b1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                en,
  input  logic [DIGITS*4-1:0] bcd_in,
  output logic [3:0]          num_out,
  output logic [IDX_W-1:0]    ctrl_led,
  output logic                blank,
  output logic                frame_done
);

  if (SCAN_DIV < 2 || BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV) begin : g_bad_params
    $error("led_scan_driver: require SCAN_DIV>=2 and 0<=BLANK_CYC<SCAN_DIV");
  end

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic                slot_start;
  logic                slot_end;
  logic                in_blank;
  logic [IDX_W-1:0]    digit_idx;
  logic [DIGITS*4-1:0] shadow;
  logic                snap;
  logic [DIGITS*4-1:0] frame_val;
  logic [3:0]          cur_num;
  logic                cur_hidden;

  led_scan_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .en         (en),
    .slot_start (slot_start),
    .slot_end   (slot_end),
    .in_blank   (in_blank)
  );

  // On the frame-start cycle the shadow is loaded in the same edge as the
  // first digit is registered, so look through to bcd_in for that cycle.
  assign snap       = en && slot_start && (digit_idx == '0);
  assign frame_val  = snap ? bcd_in : shadow;
  assign cur_num    = digit_num(frame_val, digit_idx);
  assign cur_hidden = digit_hidden(frame_val, digit_idx, LZB_EN);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      digit_idx  <= '0;
      shadow     <= '0;
      num_out    <= '0;
      ctrl_led   <= '0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= en && slot_end && (digit_idx == IDX_LAST);
      blank      <= !en || in_blank || cur_hidden;
      if (snap) shadow <= bcd_in;
      if (en) begin
        // Digit value/select change only at slot start, never mid-slot.
        if (slot_start) begin
          num_out  <= cur_num;
          ctrl_led <= digit_idx;
        end
        if (slot_end) digit_idx <= digit_idx + IDX_W'(1);
      end
    end
  end

endmodule
